// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
// Queue entries pair each instruction with the PC it was fetched from.
package fetch_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic {
    FETCH,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch stage bus bundle: instruction memory request/ack,
// decode-side valid/ready delivery, and datapath redirect.
interface fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data,
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  inst_ready,
    input  redirect,
    input  redirect_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output inst_ready,
    output redirect,
    output redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: circular buffer of {pc, instr} entries.
// Flush wins over push/pop; the caller never pushes when full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] count_nxt_o,
  output fetch_entry_t head_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          pop_ok;

  assign pop_ok = pop_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_ok);
    if (flush_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= entry_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  assign count_o     = cnt_q;
  assign count_nxt_o = cnt_d;
  assign head_o      = mem_q[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, one-deep
// imem handshake, prefetch queue and redirect/discard control.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  fetch_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic          done;
  logic          push;
  logic          pop;
  logic          room;
  logic [31:0]   target;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  fetch_entry_t  entry;
  fetch_entry_t  head;

  assign done   = req_q && bus.imem_ack;
  assign target = bus.redirect_pc & ~32'h3;
  assign push   = (state_q == FETCH) && done && !bus.redirect;
  assign pop    = bus.inst_valid && bus.inst_ready && !bus.redirect;
  assign room   = cnt_nxt < CW'(DEPTH);
  assign entry  = '{pc: pc_q, instr: bus.imem_data};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .entry_i     (entry),
    .pop_i       (pop),
    .flush_i     (bus.redirect),
    .count_o     (cnt),
    .count_nxt_o (cnt_nxt),
    .head_o      (head)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    if (bus.redirect) begin
      pc_d = target;
      // A stale request must finish on the bus at its old address.
      if (req_q && !bus.imem_ack) begin
        state_d = DISCARD;
      end else begin
        state_d = FETCH;
        req_d   = 1'b1;
        addr_d  = target;
      end
    end else if (state_q == DISCARD) begin
      if (done) begin
        state_d = FETCH;
        req_d   = room;
        addr_d  = pc_q;
      end
    end else if (done || !req_q) begin
      if (done) begin
        pc_d = pc_q + PC_STEP;
      end
      req_d  = room;
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = (cnt != '0);
  assign bus.inst_data  = head.instr;
  assign bus.inst_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a wait-state memory responder.
// Each task drives one scenario and checks outputs 1ns after the edge.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_if bus ();

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int wait_n = 0;
  int wcnt = 0;
  bit auto_en = 1'b1;
  logic man_ack = 1'b0;
  logic [31:0] man_data = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  always @(negedge clk) begin
    if (!auto_en) begin
      bus.imem_ack  = man_ack;
      bus.imem_data = man_data;
      wcnt = 0;
    end else if (bus.imem_req) begin
      if (wcnt == wait_n) begin
        bus.imem_ack  = 1'b1;
        bus.imem_data = mem_word(bus.imem_addr);
        wcnt = 0;
      end else begin
        bus.imem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      bus.imem_ack = 1'b0;
      wcnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int w, input logic rdy);
    rst = 1'b1;
    auto_en = 1'b1;
    wait_n = w;
    bus.inst_ready = rdy;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.inst_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    tick();
    tick();
    vecs++;
    if (bus.imem_req !== 1'b0) begin
      errs++; $display("FAIL rst_req: got %b want 0", bus.imem_req);
    end
    vecs++;
    if (bus.imem_addr !== 32'h0) begin
      errs++; $display("FAIL rst_addr: got %h want 0", bus.imem_addr);
    end
    vecs++;
    if (bus.inst_valid !== 1'b0) begin
      errs++; $display("FAIL rst_valid: got %b want 0", bus.inst_valid);
    end
    vecs++;
    if (bus.inst_data !== 32'h0) begin
      errs++; $display("FAIL rst_data: got %h want 0", bus.inst_data);
    end
    vecs++;
    if (bus.inst_pc !== 32'h0) begin
      errs++; $display("FAIL rst_pc: got %h want 0", bus.inst_pc);
    end
  endtask

  task automatic test_zero_wait();
    do_reset(0, 1'b1);
    tick();
    vecs++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errs++;
      $display("FAIL zw_first_req: got %b/%h want 1/0", bus.imem_req, bus.imem_addr);
    end
    vecs++;
    if (bus.inst_valid !== 1'b0) begin
      errs++; $display("FAIL zw_early_valid: got %b want 0", bus.inst_valid);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      vecs++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * k)) begin
        errs++;
        $display("FAIL zw_pc%0d: got %b/%h want 1/%h", k, bus.inst_valid, bus.inst_pc, 4 * k);
      end
      vecs++;
      if (bus.inst_data !== mem_word(32'(4 * k))) begin
        errs++;
        $display("FAIL zw_data%0d: got %h want %h", k, bus.inst_data, mem_word(32'(4 * k)));
      end
    end
  endtask

  task automatic test_wait_states();
    logic ev;
    logic [31:0] ea;
    logic [31:0] ep;
    do_reset(2, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      tick();
      ea = 32'(((c - 1) / 3) * 4);
      ev = (c >= 4) && ((c % 3) == 1);
      ep = 32'(((c - 4) / 3) * 4);
      vecs++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== ea) begin
        errs++;
        $display("FAIL ws_addr c%0d: got %b/%h want 1/%h", c, bus.imem_req, bus.imem_addr, ea);
      end
      vecs++;
      if (bus.inst_valid !== ev) begin
        errs++;
        $display("FAIL ws_valid c%0d: got %b want %b", c, bus.inst_valid, ev);
      end
      if (ev) begin
        vecs++;
        if (bus.inst_pc !== ep) begin
          errs++; $display("FAIL ws_pc c%0d: got %h want %h", c, bus.inst_pc, ep);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i >= 5) begin
        vecs++;
        if (bus.imem_req !== 1'b0) begin
          errs++; $display("FAIL bp_req_i%0d: got %b want 0", i, bus.imem_req);
        end
      end
    end
    vecs++;
    if (dut.cnt !== 3'd4) begin
      errs++; $display("FAIL bp_count: got %0d want 4", dut.cnt);
    end
    vecs++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin
      errs++;
      $display("FAIL bp_head: got %b/%h want 1/0", bus.inst_valid, bus.inst_pc);
    end
    bus.inst_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) begin
        vecs++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
          errs++;
          $display("FAIL bp_resume: got %b/%h want 1/10", bus.imem_req, bus.imem_addr);
        end
      end
      vecs++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * k)
          || bus.inst_data !== mem_word(32'(4 * k))) begin
        errs++;
        $display("FAIL bp_drain%0d: got %b/%h/%h want 1/%h/%h", k, bus.inst_valid,
                 bus.inst_pc, bus.inst_data, 4 * k, mem_word(32'(4 * k)));
      end
    end
  endtask

  task automatic test_redirect_discard();
    bit found;
    bit stale;
    do_reset(3, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      found = bus.imem_req && (bus.imem_addr == 32'h8);
    end
    vecs++;
    if (!found) begin
      errs++; $display("FAIL rd_reach8: got none want req to 00000008");
    end
    tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    bus.redirect = 1'b0;
    vecs++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin
      errs++;
      $display("FAIL rd_stale_hold: got %b/%h want 1/8", bus.imem_req, bus.imem_addr);
    end
    vecs++;
    if (bus.inst_valid !== 1'b0) begin
      errs++; $display("FAIL rd_flush: got %b want 0", bus.inst_valid);
    end
    found = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.inst_valid) stale = 1'b1;
      found = bus.imem_req && (bus.imem_addr == 32'h40);
    end
    vecs++;
    if (!found) begin
      errs++; $display("FAIL rd_newaddr: got %h want 00000040", bus.imem_addr);
    end
    vecs++;
    if (stale) begin
      errs++; $display("FAIL rd_dropped: got entry want none");
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = bus.inst_valid;
    end
    vecs++;
    if (!found || bus.inst_pc !== 32'h40 || bus.inst_data !== mem_word(32'h40)) begin
      errs++;
      $display("FAIL rd_first_pc: got %b/%h/%h want 1/40/%h", found, bus.inst_pc,
               bus.inst_data, mem_word(32'h40));
    end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset(0, 1'b1);
    tick();
    tick();
    tick();
    vecs++;
    if (bus.inst_valid !== 1'b1 || bus.imem_addr !== 32'h8) begin
      errs++;
      $display("FAIL sc_pre: got %b/%h want 1/8", bus.inst_valid, bus.imem_addr);
    end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h103;
    tick();
    bus.redirect = 1'b0;
    vecs++;
    if (bus.inst_valid !== 1'b0) begin
      errs++; $display("FAIL sc_empty: got %b want 0", bus.inst_valid);
    end
    vecs++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
      errs++;
      $display("FAIL sc_addr: got %b/%h want 1/100", bus.imem_req, bus.imem_addr);
    end
    tick();
    vecs++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100
        || bus.inst_data !== mem_word(32'h100)) begin
      errs++;
      $display("FAIL sc_deliver: got %b/%h/%h want 1/100/%h", bus.inst_valid,
               bus.inst_pc, bus.inst_data, mem_word(32'h100));
    end
  endtask

  task automatic test_wrap();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect = 1'b0;
    vecs++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin
      errs++;
      $display("FAIL wr_addr: got %b/%h want 1/fffffffc", bus.imem_req, bus.imem_addr);
    end
    tick();
    vecs++;
    if (bus.inst_pc !== 32'hFFFF_FFFC || bus.imem_addr !== 32'h0) begin
      errs++;
      $display("FAIL wr_next: got %h/%h want fffffffc/0", bus.inst_pc, bus.imem_addr);
    end
    tick();
    vecs++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0
        || bus.inst_data !== mem_word(32'h0)) begin
      errs++;
      $display("FAIL wr_zero: got %b/%h/%h want 1/0/%h", bus.inst_valid,
               bus.inst_pc, bus.inst_data, mem_word(32'h0));
    end
  endtask

  task automatic test_async_reset();
    do_reset(3, 1'b1);
    tick();
    tick();
    auto_en = 1'b0;
    man_ack = 1'b0;
    rst = 1'b1;
    #1;
    vecs++;
    if (bus.imem_req !== 1'b0) begin
      errs++; $display("FAIL ar_drop: got %b want 0", bus.imem_req);
    end
    #1;
    rst = 1'b0;
    man_ack = 1'b1;
    man_data = 32'hDEAD_BEEF;
    tick();
    man_ack = 1'b0;
    vecs++;
    if (bus.inst_valid !== 1'b0) begin
      errs++; $display("FAIL ar_late_ack: got %b want 0", bus.inst_valid);
    end
    vecs++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errs++;
      $display("FAIL ar_restart: got %b/%h want 1/0", bus.imem_req, bus.imem_addr);
    end
    tick();
    vecs++;
    if (bus.inst_valid !== 1'b0) begin
      errs++; $display("FAIL ar_no_entry: got %b want 0", bus.inst_valid);
    end
    auto_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_data = '0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_backpressure();
    test_redirect_discard();
    test_redirect_same_cycle();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
